multicycle_control: RTL and testbench



---
 rtl/multicycle_control.sv | 244 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with memory handshake and traps.
// Optional performance counters are enabled by defining MULTICYCLE_CONTROL_PERF_EN.
module multicycle_control #(
  parameter int OPCODE_W    = 7,
  parameter int ALU_OP_W    = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                branch,
  output logic                jump,
  output logic                mem_read,
  output logic                mem_write,
  output logic                alu_src,
  output logic                reg_write,
  output logic [1:0]          mem_to_reg,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal,
  output logic                mem_err,
`ifdef MULTICYCLE_CONTROL_PERF_EN
  output logic [31:0]         retired,
  output logic [31:0]         stall_cycles,
`endif
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_R     = 3'd0,
    C_I     = 3'd1,
    C_LOAD  = 3'd2,
    C_STORE = 3'd3,
    C_BR    = 3'd4,
    C_JAL   = 3'd5,
    C_JALR  = 3'd6
  } class_t;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_I    = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_LOAD = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_STOR = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_BR   = OPCODE_W'(7'b1100011);
  localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(7'b1101111);
  localparam logic [OPCODE_W-1:0] OP_JALR = OPCODE_W'(7'b1100111);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  // Last waiting cycle allowed: the counter would reach MEM_TIMEOUT on this one.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  class_t           class_q, class_d;
  logic             illegal_q, illegal_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting_s;
  logic [2:0]       aop3_s;

  // {alu_src, alu_op[2:0]} selected by the latched class
  function automatic logic [3:0] class_alu(input class_t c);
    logic [3:0] r;
    case (c)
      C_R:     r = {1'b0, 3'd2};
      C_I:     r = {1'b1, 3'd3};
      C_LOAD:  r = {1'b1, 3'd0};
      C_STORE: r = {1'b1, 3'd0};
      C_BR:    r = {1'b0, 3'd1};
      C_JAL:   r = {1'b0, 3'd4};
      C_JALR:  r = {1'b1, 3'd4};
      default: r = 4'd0;
    endcase
    return r;
  endfunction

  // Next-state, class latch, sticky traps and wait counter
  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    illegal_d = illegal_q;
    mem_err_d = mem_err_q;
    cnt_d     = '0;
    waiting_s = 1'b0;
    case (state_q)
      S_FETCH: begin
        waiting_s = 1'b1;
        if (mem_ready) state_d = S_DECODE;
        else           state_d = S_FETCH;
      end
      S_DECODE: begin
        state_d = S_EXEC;
        case (opcode)
          OP_R:    class_d = C_R;
          OP_I:    class_d = C_I;
          OP_LOAD: class_d = C_LOAD;
          OP_STOR: class_d = C_STORE;
          OP_BR:   class_d = C_BR;
          OP_JAL:  class_d = C_JAL;
          OP_JALR: class_d = C_JALR;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_TRAP;
          end
        endcase
      end
      S_EXEC: begin
        case (class_q)
          C_BR:           state_d = S_FETCH;
          C_LOAD, C_STORE: state_d = S_MEM;
          default:        state_d = S_WB;
        endcase
      end
      S_MEM: begin
        waiting_s = 1'b1;
        if (!mem_ready)              state_d = S_MEM;
        else if (class_q == C_STORE) state_d = S_FETCH;
        else                         state_d = S_WB;
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    // mem_ready on the final allowed cycle wins over the timeout
    if (waiting_s && !mem_ready) begin
      if ((MEM_TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
        mem_err_d = 1'b1;
        state_d   = S_TRAP;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      class_q   <= C_R;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Datapath controls decoded from state and latched class
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 2'b00;
    aop3_s     = 3'd0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
      end
      S_EXEC: begin
        {alu_src, aop3_s} = class_alu(class_q);
        branch   = (class_q == C_BR);
        pc_write = (class_q == C_BR);
        jump     = (class_q == C_JAL) || (class_q == C_JALR);
      end
      S_MEM: begin
        {alu_src, aop3_s} = class_alu(class_q);
        if (class_q == C_STORE) begin
          mem_write = 1'b1;
          pc_write  = mem_ready;
        end else begin
          mem_read = 1'b1;
        end
      end
      S_WB: begin
        {alu_src, aop3_s} = class_alu(class_q);
        reg_write = 1'b1;
        pc_write  = 1'b1;
        if (class_q == C_LOAD)                          mem_to_reg = 2'b01;
        else if ((class_q == C_JAL) || (class_q == C_JALR)) mem_to_reg = 2'b10;
        else                                            mem_to_reg = 2'b00;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

  assign alu_op  = ALU_OP_W'(aop3_s);
  assign illegal = illegal_q;
  assign mem_err = mem_err_q;
  assign state   = state_q;

`ifdef MULTICYCLE_CONTROL_PERF_EN
  logic [31:0] retired_q, retired_d;
  logic [31:0] stall_q, stall_d;

  // Retire and stall counting; TRAP emits no strobes and never waits, so both freeze there
  always_comb begin
    retired_d = retired_q;
    stall_d   = stall_q;
    if (pc_write && (state_q != S_TRAP)) retired_d = retired_q + 32'd1;
    else                                 retired_d = retired_q;
    if (waiting_s && !mem_ready) stall_d = stall_q + 32'd1;
    else                         stall_d = stall_q;
  end

  // Performance counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= 32'd0;
      stall_q   <= 32'd0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign retired      = retired_q;
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Vector-table bench for multicycle_control: dut 0 uses MEM_TIMEOUT=16, dut 1 uses MEM_TIMEOUT=4.
module tb_multicycle_control;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  // Packed output word: {pc,ir,br,jp,mr,mw,as,rw,m2r[1:0],aop[3:0],il,me}
  localparam logic [15:0] K_PC = 16'h8000;
  localparam logic [15:0] K_IR = 16'h4000;
  localparam logic [15:0] K_BR = 16'h2000;
  localparam logic [15:0] K_JP = 16'h1000;
  localparam logic [15:0] K_MR = 16'h0800;
  localparam logic [15:0] K_MW = 16'h0400;
  localparam logic [15:0] K_AS = 16'h0200;
  localparam logic [15:0] K_RW = 16'h0100;
  localparam logic [15:0] K_IL = 16'h0002;
  localparam logic [15:0] K_ME = 16'h0001;

  typedef struct packed {
    logic        sel;
    logic        rst;
    logic [6:0]  op;
    logic        rdy;
    logic [2:0]  st;
    logic [15:0] outs;
  } vec_t;

  typedef struct packed {
    logic        sel;
    logic [2:0]  st;
    logic [15:0] outs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       mem_ready = 1'b0;

  logic       pc_write [2];
  logic       ir_write [2];
  logic       branch [2];
  logic       jump [2];
  logic       mem_read [2];
  logic       mem_write [2];
  logic       alu_src [2];
  logic       reg_write [2];
  logic [1:0] mem_to_reg [2];
  logic [3:0] alu_op [2];
  logic       illegal [2];
  logic       mem_err [2];
  logic [2:0] st [2];
`ifdef MULTICYCLE_CONTROL_PERF_EN
  logic [31:0] retired [2];
  logic [31:0] stall_cycles [2];
`endif

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  multicycle_control #(.OPCODE_W(7), .ALU_OP_W(4), .MEM_TIMEOUT(16)) u_dut0 (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write[0]), .ir_write(ir_write[0]), .branch(branch[0]), .jump(jump[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .alu_src(alu_src[0]),
    .reg_write(reg_write[0]), .mem_to_reg(mem_to_reg[0]), .alu_op(alu_op[0]),
    .illegal(illegal[0]), .mem_err(mem_err[0]),
`ifdef MULTICYCLE_CONTROL_PERF_EN
    .retired(retired[0]), .stall_cycles(stall_cycles[0]),
`endif
    .state(st[0])
  );

  multicycle_control #(.OPCODE_W(7), .ALU_OP_W(4), .MEM_TIMEOUT(4)) u_dut1 (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write[1]), .ir_write(ir_write[1]), .branch(branch[1]), .jump(jump[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .alu_src(alu_src[1]),
    .reg_write(reg_write[1]), .mem_to_reg(mem_to_reg[1]), .alu_op(alu_op[1]),
    .illegal(illegal[1]), .mem_err(mem_err[1]),
`ifdef MULTICYCLE_CONTROL_PERF_EN
    .retired(retired[1]), .stall_cycles(stall_cycles[1]),
`endif
    .state(st[1])
  );

  function automatic logic [15:0] m2r(input logic [1:0] v);
    return {8'h00, v, 6'h00};
  endfunction

  function automatic logic [15:0] aop(input logic [3:0] v);
    return {10'h000, v, 2'b00};
  endfunction

  function automatic logic [15:0] obs(input int d);
    return {pc_write[d], ir_write[d], branch[d], jump[d], mem_read[d], mem_write[d],
            alu_src[d], reg_write[d], mem_to_reg[d], alu_op[d], illegal[d], mem_err[d]};
  endfunction

  task automatic add(input logic s, input logic r, input logic [6:0] op, input logic rdy,
                     input logic [2:0] est, input logic [15:0] eo);
    vec_t v;
    v.sel = s; v.rst = r; v.op = op; v.rdy = rdy; v.st = est; v.outs = eo;
    vecs.push_back(v);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  initial begin
    int   n;
    exp_t e;
    int   d;

    // reset
    add(0, 1, OP_R, 0, 3'd0, K_MR);
    // R-type, zero-wait
    add(0, 0, OP_R, 1, 3'd0, K_MR | K_IR);
    add(0, 0, OP_R, 1, 3'd1, 16'h0000);
    add(0, 0, OP_R, 1, 3'd2, aop(4'd2));
    add(0, 0, OP_R, 1, 3'd4, K_RW | K_PC | aop(4'd2));
    // I-type
    add(0, 0, OP_I, 1, 3'd0, K_MR | K_IR);
    add(0, 0, OP_I, 1, 3'd1, 16'h0000);
    add(0, 0, OP_I, 1, 3'd2, K_AS | aop(4'd3));
    add(0, 0, OP_I, 1, 3'd4, K_RW | K_PC | K_AS | aop(4'd3));
    // LOAD with three wait cycles in MEM: 8 cycles total
    add(0, 0, OP_LD, 1, 3'd0, K_MR | K_IR);
    add(0, 0, OP_LD, 1, 3'd1, 16'h0000);
    add(0, 0, OP_LD, 1, 3'd2, K_AS);
    for (int i = 0; i < 3; i++) add(0, 0, OP_LD, 0, 3'd3, K_MR | K_AS);
    add(0, 0, OP_LD, 1, 3'd3, K_MR | K_AS);
    add(0, 0, OP_LD, 1, 3'd4, K_RW | K_PC | K_AS | m2r(2'b01));
    // STORE then BR back to back
    add(0, 0, OP_ST, 1, 3'd0, K_MR | K_IR);
    add(0, 0, OP_ST, 1, 3'd1, 16'h0000);
    add(0, 0, OP_ST, 1, 3'd2, K_AS);
    add(0, 0, OP_ST, 1, 3'd3, K_MW | K_AS | K_PC);
    add(0, 0, OP_BR, 1, 3'd0, K_MR | K_IR);
    add(0, 0, OP_BR, 1, 3'd1, 16'h0000);
    add(0, 0, OP_BR, 1, 3'd2, K_BR | K_PC | aop(4'd1));
    // JAL and JALR
    add(0, 0, OP_JAL, 1, 3'd0, K_MR | K_IR);
    add(0, 0, OP_JAL, 1, 3'd1, 16'h0000);
    add(0, 0, OP_JAL, 1, 3'd2, K_JP | aop(4'd4));
    add(0, 0, OP_JAL, 1, 3'd4, K_RW | K_PC | m2r(2'b10) | aop(4'd4));
    add(0, 0, OP_JALR, 1, 3'd0, K_MR | K_IR);
    add(0, 0, OP_JALR, 1, 3'd1, 16'h0000);
    add(0, 0, OP_JALR, 1, 3'd2, K_JP | K_AS | aop(4'd4));
    add(0, 0, OP_JALR, 1, 3'd4, K_RW | K_PC | K_AS | m2r(2'b10) | aop(4'd4));
    // illegal opcode traps and stays trapped even with mem_ready high
    add(0, 0, OP_BAD, 1, 3'd0, K_MR | K_IR);
    add(0, 0, OP_BAD, 1, 3'd1, 16'h0000);
    for (int i = 0; i < 20; i++) add(0, 0, OP_BAD, 1, 3'd7, K_IL);
    add(0, 1, OP_R, 0, 3'd0, K_MR);
    // FETCH timeout on the MEM_TIMEOUT=4 instance
    for (int i = 0; i < 4; i++) add(1, 0, OP_R, 0, 3'd0, K_MR);
    for (int i = 0; i < 3; i++) add(1, 0, OP_R, 0, 3'd7, K_ME);
    add(1, 1, OP_R, 0, 3'd0, K_MR);
    // mem_ready on the timeout cycle wins
    for (int i = 0; i < 3; i++) add(1, 0, OP_R, 0, 3'd0, K_MR);
    add(1, 0, OP_R, 1, 3'd0, K_MR | K_IR);
    add(1, 0, OP_R, 1, 3'd1, 16'h0000);
    add(1, 0, OP_R, 1, 3'd2, aop(4'd2));
    add(1, 0, OP_R, 1, 3'd4, K_RW | K_PC | aop(4'd2));
    // MEM timeout on a load
    add(1, 0, OP_LD, 1, 3'd0, K_MR | K_IR);
    add(1, 0, OP_LD, 1, 3'd1, 16'h0000);
    add(1, 0, OP_LD, 1, 3'd2, K_AS);
    for (int i = 0; i < 4; i++) add(1, 0, OP_LD, 0, 3'd3, K_MR | K_AS);
    add(1, 0, OP_LD, 0, 3'd7, K_ME);
    add(1, 1, OP_R, 0, 3'd0, K_MR);
    // reset asserted in the middle of a store wait
    add(1, 0, OP_ST, 1, 3'd0, K_MR | K_IR);
    add(1, 0, OP_ST, 1, 3'd1, 16'h0000);
    add(1, 0, OP_ST, 1, 3'd2, K_AS);
    add(1, 0, OP_ST, 0, 3'd3, K_MW | K_AS);
    add(1, 1, OP_ST, 0, 3'd0, K_MR);
    add(1, 0, OP_R, 0, 3'd0, K_MR);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rst       = vecs[i].rst;
      opcode    = vecs[i].op;
      mem_ready = vecs[i].rdy;
      sb.push_back({vecs[i].sel, vecs[i].st, vecs[i].outs});
      #3;
      e = sb.pop_front();
      d = e.sel ? 1 : 0;
      n_checks++;
      if (st[d] !== e.st) begin
        n_fail++;
        $display("FAIL state vec %0d dut%0d: got %0d, expected %0d", i, d, st[d], e.st);
      end
      n_checks++;
      if (obs(d) !== e.outs) begin
        n_fail++;
        $display("FAIL outputs vec %0d dut%0d: got %h, expected %h", i, d, obs(d), e.outs);
      end
    end

    // FETCH timeout latency for both instances, measured from reset release
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #3;
    n = 0;
    while (st[1] != 3'd7 && n < 20) begin
      n++;
      @(posedge clk);
      #4;
    end
    check_int("fetch_wait_cycles_t4", n, 4);
    check_int("dut0_still_fetch", int'(st[0]), 0);
    check_int("dut1_mem_err", int'(mem_err[1]), 1);
    while (st[0] != 3'd7 && n < 40) begin
      n++;
      @(posedge clk);
      #4;
    end
    check_int("fetch_wait_cycles_t16", n, 16);
    check_int("dut0_mem_err", int'(mem_err[0]), 1);
    check_int("dut0_illegal_clear", int'(illegal[0]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
